alu_queue: RTL and testbench
============================

ALU_QUEUE -- requirements
Module: alu_queue

Interface
REQ-001 Parameter XLEN, default 32, operand and result width.
REQ-002 Parameter ROB_W, default 5, ROB tag width.
REQ-003 Parameter DEPTH, default 4, input queue entries; power of two, at least 2.
REQ-004 clk_in  input  1  system clock; the block SHALL use one clock.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 rdy_in  input  1  global enable; low SHALL freeze all state.
REQ-007 _clear  input  1  misprediction flush.
REQ-008 _alu_ready  input  1  RS issue strobe.
REQ-009 _alu_rob_id  input  ROB_W  destination tag.
REQ-010 _alu_type  input  7  RV32 opcode field.
REQ-011 _alu_op  input  4  operation select.
REQ-012 _alu_v1, _alu_v2  input  XLEN each  operands.
REQ-013 _alu_full  output  1  queue full; RS SHALL NOT issue while high.
REQ-014 _cdb_grant  input  1  CDB arbiter accepts the current result.
REQ-015 _cdb_ready, _cdb_rob_id, _cdb_value  output  1/ROB_W/XLEN  result broadcast.

Function
REQ-016 Enqueue SHALL occur on an edge with rdy_in=1, _alu_ready=1, _alu_full=0; issue while full SHALL be dropped.
REQ-017 _alu_full SHALL be combinational: count==DEPTH; a same-cycle pop SHALL NOT clear it for that cycle.
REQ-018 Result register SHALL load from the queue head when empty, or when _cdb_grant=1 in the same cycle; the head is popped on that edge.
REQ-019 Latency: entry written at edge N SHALL reach _cdb_ready=1 after edge N+1 at the earliest; one result per cycle under continuous grant.
REQ-020 _cdb_ready, _cdb_rob_id, _cdb_value SHALL hold stable until sampled with _cdb_grant=1.
REQ-021 Enqueue and pop SHALL be allowed on the same edge; count is unchanged; pointers wrap modulo DEPTH.
REQ-022 Type 0110011, op 0..9: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (unsigned v1<v2).
REQ-023 Type 0010011, op 0..8: ADD, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
REQ-024 Type 1100011, op 0..5: EQ, GE, GEU, LT, LTU, NE; result 1 or 0, zero-extended.
REQ-025 Types 1101111, 1100111, 0010111 SHALL produce v1+v2; any other type SHALL produce 0.
REQ-026 Shift amount SHALL be v2[log2(XLEN)-1:0]; add and sub SHALL wrap modulo 2^XLEN.
REQ-027 An undefined op within a defined type SHALL produce 0.
REQ-028 _clear SHALL empty the queue and result register on the next enabled edge, with priority over enqueue and grant.
REQ-029 rdy_in=0 SHALL ignore _alu_ready, _cdb_grant and _clear; outputs hold.

Reset
REQ-030 rst_in SHALL set count, pointers, _cdb_ready, _cdb_rob_id and _cdb_value to 0, and the multiply state machine to IDLE; it overrides rdy_in.
REQ-031 Reset asserted mid-operation SHALL discard queued entries and in-flight multiplies with no broadcast.

Configuration
REQ-032 With macro ALU_MUL_EN defined, type 0110011 op 10 SHALL be MUL, giving the low XLEN bits of v1*v2.
REQ-033 MUL SHALL take a two-state machine, IDLE->MUL on pop and MUL->IDLE on the next enabled edge, loading the result register one edge later than other ops.
REQ-034 In state MUL, pops SHALL stall; _clear SHALL return the state machine to IDLE.
REQ-035 Without ALU_MUL_EN, op 10 SHALL produce 0 at normal latency, and no multiplier or state machine SHALL be synthesised.

Structure
REQ-036 Package alu_pkg SHALL hold the opcode constants (OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_AUIPC), the per-type op-code enums and the default XLEN.
REQ-037 The combinational compute SHALL be sub-module alu_core (inputs type, op, v1, v2; output result).
REQ-038 The queue and the result register SHALL reside in alu_queue.

Verification
REQ-039 The bench SHALL cover: issue type 0110011 op1, v1=5, v2=7, tag 3, grant held -> _cdb_value=0xFFFFFFFE, tag 3, ready exactly one cycle, two edges after issue.
REQ-040 The bench SHALL cover: grant low, issue 5 ops, DEPTH=4 -> _alu_full high after the 4th issue; 5th op dropped; results drain in order after grant.
REQ-041 The bench SHALL cover: op SRA, v1=0x80000000, v2=0x21 -> 0xC0000000 (shamt 1); SLTU 1 vs 0xFFFFFFFF -> 1.
REQ-042 The bench SHALL cover: 3 entries queued, then _clear with a simultaneous issue -> queue empty, _cdb_ready=0, issued op discarded.
REQ-043 The bench SHALL cover: rdy_in low for 3 cycles during drain -> outputs frozen; resume -> no loss or duplication.
REQ-044 The bench SHALL cover, under ALU_MUL_EN: MUL 0x10000 x 0x10001 -> 0x00010000, three edges after issue; the following ADD is delayed one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: RV32 opcode field values, per-type operation encodings,
// the default datapath width and the MUL sequencing states.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        R_ADD  = 4'd0,
        R_SUB  = 4'd1,
        R_AND  = 4'd2,
        R_OR   = 4'd3,
        R_XOR  = 4'd4,
        R_SLL  = 4'd5,
        R_SRL  = 4'd6,
        R_SRA  = 4'd7,
        R_SLT  = 4'd8,
        R_SLTU = 4'd9,
        R_MUL  = 4'd10
    } r_op_e;

    typedef enum logic [3:0] {
        I_ADD  = 4'd0,
        I_AND  = 4'd1,
        I_OR   = 4'd2,
        I_XOR  = 4'd3,
        I_SLL  = 4'd4,
        I_SRL  = 4'd5,
        I_SRA  = 4'd6,
        I_SLT  = 4'd7,
        I_SLTU = 4'd8
    } i_op_e;

    typedef enum logic [3:0] {
        B_EQ  = 4'd0,
        B_GE  = 4'd1,
        B_GEU = 4'd2,
        B_LT  = 4'd3,
        B_LTU = 4'd4,
        B_NE  = 4'd5
    } b_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath selected by opcode type and op field.
// Defining ALU_MUL_EN adds the R-type MUL operation (op 10).
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [6:0]      type_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] v1_i,
    input  logic [XLEN-1:0] v2_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_s;
    logic           lt_u;
    logic           eq;

    assign shamt = v2_i[SHW-1:0];
    assign lt_s  = $signed(v1_i) < $signed(v2_i);
    assign lt_u  = v1_i < v2_i;
    assign eq    = v1_i == v2_i;

    always_comb begin
        result_o = '0;
        case (type_i)
            OP_R: begin
                case (op_i)
                    R_ADD:   result_o = v1_i + v2_i;
                    R_SUB:   result_o = v1_i - v2_i;
                    R_AND:   result_o = v1_i & v2_i;
                    R_OR:    result_o = v1_i | v2_i;
                    R_XOR:   result_o = v1_i ^ v2_i;
                    R_SLL:   result_o = v1_i << shamt;
                    R_SRL:   result_o = v1_i >> shamt;
                    R_SRA:   result_o = $unsigned($signed(v1_i) >>> shamt);
                    R_SLT:   result_o = {{(XLEN-1){1'b0}}, lt_s};
                    R_SLTU:  result_o = {{(XLEN-1){1'b0}}, lt_u};
`ifdef ALU_MUL_EN
                    R_MUL:   result_o = v1_i * v2_i;
`endif
                    default: result_o = '0;
                endcase
            end
            OP_I: begin
                case (op_i)
                    I_ADD:   result_o = v1_i + v2_i;
                    I_AND:   result_o = v1_i & v2_i;
                    I_OR:    result_o = v1_i | v2_i;
                    I_XOR:   result_o = v1_i ^ v2_i;
                    I_SLL:   result_o = v1_i << shamt;
                    I_SRL:   result_o = v1_i >> shamt;
                    I_SRA:   result_o = $unsigned($signed(v1_i) >>> shamt);
                    I_SLT:   result_o = {{(XLEN-1){1'b0}}, lt_s};
                    I_SLTU:  result_o = {{(XLEN-1){1'b0}}, lt_u};
                    default: result_o = '0;
                endcase
            end
            OP_B: begin
                case (op_i)
                    B_EQ:    result_o = {{(XLEN-1){1'b0}}, eq};
                    B_GE:    result_o = {{(XLEN-1){1'b0}}, !lt_s};
                    B_GEU:   result_o = {{(XLEN-1){1'b0}}, !lt_u};
                    B_LT:    result_o = {{(XLEN-1){1'b0}}, lt_s};
                    B_LTU:   result_o = {{(XLEN-1){1'b0}}, lt_u};
                    B_NE:    result_o = {{(XLEN-1){1'b0}}, !eq};
                    default: result_o = '0;
                endcase
            end
            OP_JAL, OP_JALR, OP_AUIPC: result_o = v1_i + v2_i;
            default:                   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_queue.sv
// ALU issue queue feeding a single CDB result register through alu_core.
// Defining ALU_MUL_EN adds a two-state MUL sequencer that delays MUL results by one edge.
module alu_queue
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ROB_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _alu_ready,
    input  logic [ROB_W-1:0] _alu_rob_id,
    input  logic [6:0]       _alu_type,
    input  logic [3:0]       _alu_op,
    input  logic [XLEN-1:0]  _alu_v1,
    input  logic [XLEN-1:0]  _alu_v2,
    output logic             _alu_full,
    input  logic             _cdb_grant,
    output logic             _cdb_ready,
    output logic [ROB_W-1:0] _cdb_rob_id,
    output logic [XLEN-1:0]  _cdb_value
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ROB_W + 11 + 2 * XLEN;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic [ROB_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  val_q, val_d;

    logic [ROB_W-1:0] head_tag;
    logic [6:0]       head_type;
    logic [3:0]       head_op;
    logic [XLEN-1:0]  head_v1, head_v2, head_result;
    logic             enq, pop, load_now;

    assign {head_tag, head_type, head_op, head_v1, head_v2} = mem_q[rd_ptr_q];

    alu_core #(.XLEN(XLEN)) u_core (
        .type_i   (head_type),
        .op_i     (head_op),
        .v1_i     (head_v1),
        .v2_i     (head_v2),
        .result_o (head_result)
    );

    assign _alu_full = (count_q == CW'(DEPTH));
    assign enq       = _alu_ready && !_alu_full;

`ifdef ALU_MUL_EN
    mul_state_e       state_q, state_d;
    logic [ROB_W-1:0] mul_tag_q, mul_tag_d;
    logic [XLEN-1:0]  mul_val_q, mul_val_d;
    logic             head_is_mul;

    assign head_is_mul = (head_type == OP_R) && (head_op == R_MUL);
    assign pop         = (count_q != '0) && (!ready_q || _cdb_grant) && (state_q == ST_IDLE);
    assign load_now    = pop && !head_is_mul;
`else
    assign pop         = (count_q != '0) && (!ready_q || _cdb_grant);
    assign load_now    = pop;
`endif

    // A granted result frees the register; the head refills it on the same edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ready_d  = ready_q;
        tag_d    = tag_q;
        val_d    = val_q;
`ifdef ALU_MUL_EN
        state_d   = state_q;
        mul_tag_d = mul_tag_q;
        mul_val_d = mul_val_q;
`endif
        if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(enq) - CW'(pop);
        if (ready_q && _cdb_grant) ready_d = 1'b0;
        if (load_now) begin
            ready_d = 1'b1;
            tag_d   = head_tag;
            val_d   = head_result;
        end
`ifdef ALU_MUL_EN
        if (pop && head_is_mul) begin
            state_d   = ST_MUL;
            mul_tag_d = head_tag;
            mul_val_d = head_result;
        end
        if (state_q == ST_MUL) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            tag_d   = mul_tag_q;
            val_d   = mul_val_q;
        end
`endif
        if (_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ready_d  = 1'b0;
            tag_d    = '0;
            val_d    = '0;
`ifdef ALU_MUL_EN
            state_d  = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            tag_q    <= '0;
            val_q    <= '0;
`ifdef ALU_MUL_EN
            state_q   <= ST_IDLE;
            mul_tag_q <= '0;
            mul_val_q <= '0;
`endif
        end else if (rdy_in) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            tag_q    <= tag_d;
            val_q    <= val_d;
`ifdef ALU_MUL_EN
            state_q   <= state_d;
            mul_tag_q <= mul_tag_d;
            mul_val_q <= mul_val_d;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && enq && !_clear)
            mem_q[wr_ptr_q] <= {_alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2};
    end

    assign _cdb_ready  = ready_q;
    assign _cdb_rob_id = tag_q;
    assign _cdb_value  = val_q;

endmodule

// File: tb/tb_alu_queue.sv
// Directed self-checking bench for alu_queue: vector table for the ALU functions plus
// hand-written sequences for full, clear, freeze, reset and (with ALU_MUL_EN) MUL timing.
module tb_alu_queue;
    import alu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;
    logic        _alu_full;
    logic        _cdb_grant;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  typ;
        logic [3:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu_queue #(.XLEN(32), .ROB_W(5), .DEPTH(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (_clear),
        ._alu_ready  (_alu_ready),
        ._alu_rob_id (_alu_rob_id),
        ._alu_type   (_alu_type),
        ._alu_op     (_alu_op),
        ._alu_v1     (_alu_v1),
        ._alu_v2     (_alu_v2),
        ._alu_full   (_alu_full),
        ._cdb_grant  (_cdb_grant),
        ._cdb_ready  (_cdb_ready),
        ._cdb_rob_id (_cdb_rob_id),
        ._cdb_value  (_cdb_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic addVec(input logic [6:0] typ, input logic [3:0] op,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] exp);
        vec_t v;
        v.typ = typ;
        v.op  = op;
        v.v1  = v1;
        v.v2  = v2;
        v.exp = exp;
        v.tag = 5'(vecs.size() + 1);
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic valid, input logic [6:0] typ, input logic [3:0] op,
                                 input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] tag);
        _alu_ready  = valid;
        _alu_type   = typ;
        _alu_op     = op;
        _alu_v1     = v1;
        _alu_v2     = v2;
        _alu_rob_id = tag;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issueOne(input logic [6:0] typ, input logic [3:0] op,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] tag);
        applyStimulus(1'b1, typ, op, v1, v2, tag);
        step();
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        addVec(OP_R, R_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
        addVec(OP_R, R_ADD,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
        addVec(OP_R, R_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        addVec(OP_R, R_OR,   32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF);
        addVec(OP_R, R_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        addVec(OP_R, R_SLL,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
        addVec(OP_R, R_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001);
        addVec(OP_R, R_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
        addVec(OP_R, R_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
        addVec(OP_R, R_SLTU, 32'd1,         32'hFFFF_FFFF, 32'h0000_0001);
        addVec(OP_R, R_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
`ifndef ALU_MUL_EN
        addVec(OP_R, 4'd10,  32'd3,         32'd4,         32'h0000_0000);
`endif
        addVec(OP_R, 4'd11,  32'd3,         32'd4,         32'h0000_0000);
        addVec(OP_R, 4'd15,  32'd3,         32'd4,         32'h0000_0000);
        addVec(OP_I, I_ADD,  32'd10,        32'hFFFF_FFFF, 32'h0000_0009);
        addVec(OP_I, I_AND,  32'h0000_00FF, 32'h0000_000F, 32'h0000_000F);
        addVec(OP_I, I_SRA,  32'hF000_0000, 32'd4,         32'hFF00_0000);
        addVec(OP_I, I_SLTU, 32'd2,         32'd3,         32'h0000_0001);
        addVec(OP_I, 4'd9,   32'd2,         32'd3,         32'h0000_0000);
        addVec(OP_B, B_EQ,   32'd5,         32'd5,         32'h0000_0001);
        addVec(OP_B, B_GE,   32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
        addVec(OP_B, B_GEU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
        addVec(OP_B, B_LT,   32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
        addVec(OP_B, B_LTU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
        addVec(OP_B, B_NE,   32'd5,         32'd5,         32'h0000_0000);
        addVec(OP_B, 4'd6,   32'd5,         32'd6,         32'h0000_0000);
        addVec(OP_JAL,   4'd0, 32'h0000_1000, 32'd4,         32'h0000_1004);
        addVec(OP_JALR,  4'd3, 32'hFFFF_FFFC, 32'd8,         32'h0000_0004);
        addVec(OP_AUIPC, 4'd0, 32'h1234_5000, 32'h0000_0678, 32'h1234_5678);
        addVec(7'b0110111, 4'd0, 32'd1,       32'd2,         32'h0000_0000);

        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        _clear     = 1'b0;
        _cdb_grant = 1'b0;
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        checkOutput("reset ready", 32'(_cdb_ready), 32'd0);
        checkOutput("reset tag",   32'(_cdb_rob_id), 32'd0);
        checkOutput("reset value", _cdb_value, 32'd0);
        checkOutput("reset full",  32'(_alu_full), 32'd0);
        rst_in = 1'b0;

        _cdb_grant = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b1, vecs[i].typ, vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].tag);
            step();
            checkOutput($sformatf("vec%0d ready early", i), 32'(_cdb_ready), 32'd0);
            applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
            step();
            checkOutput($sformatf("vec%0d ready", i), 32'(_cdb_ready), 32'd1);
            checkOutput($sformatf("vec%0d value", i), _cdb_value, vecs[i].exp);
            checkOutput($sformatf("vec%0d tag", i), 32'(_cdb_rob_id), 32'(vecs[i].tag));
            step();
            checkOutput($sformatf("vec%0d ready drop", i), 32'(_cdb_ready), 32'd0);
        end

        // Result register occupied by a pilot, then five issues against four queue slots.
        _cdb_grant = 1'b0;
        issueOne(OP_R, R_ADD, 32'h100, 32'd0, 5'd20);
        for (int k = 0; k < 5; k++) begin
            issueOne(OP_R, R_ADD, 32'(k + 1), 32'd0, 5'(21 + k));
            checkOutput($sformatf("full after issue %0d", k + 1), 32'(_alu_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        checkOutput("pilot held value", _cdb_value, 32'h100);
        checkOutput("pilot held tag", 32'(_cdb_rob_id), 32'd20);
        _cdb_grant = 1'b1;
        applyStimulus(1'b1, OP_R, R_ADD, 32'h999, 32'd0, 5'd30);
        step();
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
        checkOutput("drain full cleared", 32'(_alu_full), 32'd0);
        checkOutput("drain 0 value", _cdb_value, 32'd1);
        checkOutput("drain 0 tag", 32'(_cdb_rob_id), 32'd21);
        for (int k = 1; k < 4; k++) begin
            step();
            checkOutput($sformatf("drain %0d ready", k), 32'(_cdb_ready), 32'd1);
            checkOutput($sformatf("drain %0d value", k), _cdb_value, 32'(k + 1));
            checkOutput($sformatf("drain %0d tag", k), 32'(_cdb_rob_id), 32'(21 + k));
        end
        step();
        checkOutput("drain done", 32'(_cdb_ready), 32'd0);
        step();
        checkOutput("drain no extra", 32'(_cdb_ready), 32'd0);

        // Flush with a simultaneous issue.
        _cdb_grant = 1'b0;
        for (int k = 0; k < 4; k++) issueOne(OP_R, R_ADD, 32'(k), 32'd1, 5'(k + 1));
        applyStimulus(1'b1, OP_R, R_ADD, 32'h55, 32'd0, 5'd9);
        _clear = 1'b1;
        step();
        _clear = 1'b0;
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
        checkOutput("clear ready", 32'(_cdb_ready), 32'd0);
        checkOutput("clear full", 32'(_alu_full), 32'd0);
        _cdb_grant = 1'b1;
        step();
        step();
        checkOutput("clear stays empty", 32'(_cdb_ready), 32'd0);
        issueOne(OP_R, R_SUB, 32'd10, 32'd3, 5'd11);
        step();
        checkOutput("post clear ready", 32'(_cdb_ready), 32'd1);
        checkOutput("post clear value", _cdb_value, 32'd7);
        checkOutput("post clear tag", 32'(_cdb_rob_id), 32'd11);
        step();
        checkOutput("post clear drop", 32'(_cdb_ready), 32'd0);

        // Freeze in the middle of a drain.
        _cdb_grant = 1'b0;
        issueOne(OP_R, R_ADD, 32'hA, 32'd0, 5'd1);
        issueOne(OP_R, R_ADD, 32'hB, 32'd0, 5'd2);
        issueOne(OP_R, R_ADD, 32'hC, 32'd0, 5'd3);
        checkOutput("freeze pre value", _cdb_value, 32'hA);
        _cdb_grant = 1'b1;
        step();
        checkOutput("freeze B value", _cdb_value, 32'hB);
        rdy_in = 1'b0;
        _clear = 1'b1;
        applyStimulus(1'b1, OP_R, R_ADD, 32'hEE, 32'd0, 5'd14);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("frozen %0d ready", k), 32'(_cdb_ready), 32'd1);
            checkOutput($sformatf("frozen %0d value", k), _cdb_value, 32'hB);
            checkOutput($sformatf("frozen %0d tag", k), 32'(_cdb_rob_id), 32'd2);
        end
        rdy_in = 1'b1;
        _clear = 1'b0;
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
        step();
        checkOutput("resume C value", _cdb_value, 32'hC);
        checkOutput("resume C tag", 32'(_cdb_rob_id), 32'd3);
        step();
        checkOutput("resume done", 32'(_cdb_ready), 32'd0);

        // Reset while entries are queued.
        _cdb_grant = 1'b0;
        issueOne(OP_R, R_ADD, 32'h1, 32'd0, 5'd5);
        issueOne(OP_R, R_ADD, 32'h2, 32'd0, 5'd6);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        checkOutput("midreset ready", 32'(_cdb_ready), 32'd0);
        checkOutput("midreset value", _cdb_value, 32'd0);
        _cdb_grant = 1'b1;
        step();
        step();
        checkOutput("midreset no broadcast", 32'(_cdb_ready), 32'd0);

`ifdef ALU_MUL_EN
        // MUL occupies one extra edge and holds back the ADD behind it.
        _cdb_grant = 1'b1;
        applyStimulus(1'b1, OP_R, R_MUL, 32'h0001_0000, 32'h0001_0001, 5'd7);
        step();
        applyStimulus(1'b1, OP_R, R_ADD, 32'd2, 32'd3, 5'd8);
        step();
        applyStimulus(1'b0, 7'd0, 4'd0, 32'd0, 32'd0, 5'd0);
        checkOutput("mul busy ready", 32'(_cdb_ready), 32'd0);
        step();
        checkOutput("mul ready", 32'(_cdb_ready), 32'd1);
        checkOutput("mul value", _cdb_value, 32'h0001_0000);
        checkOutput("mul tag", 32'(_cdb_rob_id), 32'd7);
        step();
        checkOutput("after mul value", _cdb_value, 32'd5);
        checkOutput("after mul tag", 32'(_cdb_rob_id), 32'd8);
        step();
        checkOutput("after mul drop", 32'(_cdb_ready), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
